// File: rtl/alu_pipe_if.sv
// alu_pipe_if
//   Handshake and data bundle between the register-file read stage, the
//   alu_pipe block and the writeback stage.
//
//   Parameter:
//     INPUT_WIDTH  operand/result width
//
//   Signals:
//     in_valid   operands/cop valid (source -> alu)
//     in_ready   alu can accept this cycle (alu -> source)
//     reg_A      operand A, unsigned
//     reg_B      operand B, unsigned
//     cop        4-bit operation code
//     out_valid  result/flags valid (alu -> consumer)
//     out_ready  consumer accepts result (consumer -> alu)
//     result     registered result
//     OVF        carry/borrow/overflow flag
//     ILL        illegal-opcode flag
//
//   Modports:
//     master  the side that feeds operands and consumes results
//     slave   the alu itself
interface alu_pipe_if #(
  parameter int INPUT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INPUT_WIDTH-1:0] reg_A;
  logic [INPUT_WIDTH-1:0] reg_B;
  logic [3:0]             cop;
  logic                   out_valid;
  logic                   out_ready;
  logic [INPUT_WIDTH-1:0] result;
  logic                   OVF;
  logic                   ILL;

  modport master (
    output in_valid, reg_A, reg_B, cop, out_ready,
    input  in_ready, out_valid, result, OVF, ILL
  );

  modport slave (
    input  in_valid, reg_A, reg_B, cop, out_ready,
    output in_ready, out_valid, result, OVF, ILL
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe
//   Registered, valid/ready handshaked ALU placed between the register-file
//   read stage and writeback. Single-cycle ops sustain one result per cycle;
//   the optional iterative multiplier stalls the input while it runs.
//
//   Build option:
//     ALU_PIPE_MUL_EN  when defined, cop 4'b1011 is an iterative unsigned
//                      multiply (one bit of B per cycle, INPUT_WIDTH cycles).
//                      When undefined there is no multiplier and 4'b1011 is
//                      reported as an illegal opcode.
//
//   Parameters:
//     INPUT_WIDTH  operand/result width (>= 4, power of two)
//     SHAMT_W      shift-amount bits taken from reg_B
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    alu_pipe_if slave modport (in_valid/in_ready, reg_A, reg_B, cop,
//            out_valid/out_ready, result, OVF, ILL)
module alu_pipe #(
  parameter int INPUT_WIDTH = 16,
  parameter int SHAMT_W     = $clog2(INPUT_WIDTH)
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  localparam int W = INPUT_WIDTH;

  logic               out_free;
  logic               accept;
  logic               load_single;
  logic [W:0]         sum;
  logic [W:0]         diff;
  logic [2*W-1:0]     shl_wide;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       alu_res;
  logic               alu_ovf;
  logic               alu_ill;

  logic               out_valid_q;
  logic [W-1:0]       result_q;
  logic               ovf_q;
  logic               ill_q;

  // The output register counts as free when it is empty or being drained
  // this very cycle, which is what lets back-to-back ops run at full rate.
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;

  assign shamt    = bus.reg_B[SHAMT_W-1:0];
  assign sum      = {1'b0, bus.reg_A} + {1'b0, bus.reg_B};
  assign diff     = {1'b0, bus.reg_A} - {1'b0, bus.reg_B};
  // Shift into a double-width vector so the bits pushed out of the result
  // are still visible for the overflow flag.
  assign shl_wide = {{W{1'b0}}, bus.reg_A} << shamt;

  // Single-cycle operation decode; anything not listed is illegal.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.cop)
      4'b0000: ;
      4'b0001: begin
        alu_res = sum[W-1:0];
        alu_ovf = sum[W];
      end
      4'b0010: begin
        alu_res = diff[W-1:0];
        alu_ovf = diff[W];
      end
      4'b0011: alu_res = bus.reg_B;
      4'b0100: alu_res = {{(W-1){1'b0}}, bus.reg_A == bus.reg_B};
      4'b0101: alu_res = bus.reg_A & bus.reg_B;
      4'b0110: alu_res = bus.reg_A | bus.reg_B;
      4'b0111: alu_res = bus.reg_A ^ bus.reg_B;
      4'b1000: begin
        alu_res = shl_wide[W-1:0];
        alu_ovf = |shl_wide[2*W-1:W];
      end
      4'b1001: alu_res = bus.reg_A >> shamt;
      4'b1010: alu_res = {{(W-1){1'b0}}, bus.reg_A < bus.reg_B};
`ifdef ALU_PIPE_MUL_EN
      4'b1011: ;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_WAIT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               is_mul;
  logic               mul_last;
  logic               load_mul;
  logic [SHAMT_W-1:0] mul_cnt;
  logic [2*W-1:0]     mul_acc;
  logic [2*W-1:0]     mul_mcand;
  logic [W-1:0]       mul_mplier;
  logic [2*W-1:0]     acc_next;
  logic [2*W-1:0]     mul_prod;

  assign is_mul      = bus.cop == 4'b1011;
  assign load_single = accept && !is_mul;
  assign mul_last    = mul_cnt == SHAMT_W'(W - 1);
  assign acc_next    = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  // On the last step the finished product is still on acc_next; once parked
  // in MUL_WAIT it lives in mul_acc.
  assign mul_prod    = (state == MUL_WAIT) ? mul_acc : acc_next;
  assign bus.in_ready = (state == IDLE) && out_free;

  // State register for the multiply sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer: run one step per cycle, then hand the product to the output
  // register as soon as it is free, parking in MUL_WAIT if it is not.
  always_comb begin
    state_next = state;
    load_mul   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (mul_last) begin
          if (out_free) begin
            load_mul   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        if (out_free) begin
          load_mul   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift-add datapath: the multiplicand moves left and the multiplier right
  // each step, so bit 0 of the multiplier always selects the next addend.
  // The counter wraps back to zero on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (accept && is_mul) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= {{W{1'b0}}, bus.reg_A};
      mul_mplier <= bus.reg_B;
    end else if (state == MUL_RUN) begin
      mul_cnt    <= mul_cnt + 1'b1;
      mul_acc    <= acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

`else

  assign load_single  = accept;
  assign bus.in_ready = out_free;

`endif

  // Output register: loads on a completed op, otherwise holds until the
  // consumer takes it. A load in the same cycle as a drain keeps out_valid up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else if (load_single) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      ovf_q       <= alu_ovf;
      ill_q       <= alu_ill;
`ifdef ALU_PIPE_MUL_EN
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_prod[W-1:0];
      ovf_q       <= |mul_prod[2*W-1:W];
      ill_q       <= 1'b0;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.OVF       = ovf_q;
  assign bus.ILL       = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
//   Self-checking bench for alu_pipe: directed scenarios followed by a
//   randomized valid/ready run scored against an arithmetic reference model.
//   Follows ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         ovf;
    logic         ill;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_pipe_if #(.INPUT_WIDTH(W)) bus ();

  alu_pipe #(.INPUT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint unsigned av;
    longint unsigned bv;
    longint unsigned full;
    longint unsigned pw;
    exp_t e;
    av    = a;
    bv    = b;
    pw    = 64'd1 << (bv % W);
    e.r   = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (op)
      4'd0: ;
      4'd1: begin
        full  = av + bv;
        e.r   = 16'(full % 65536);
        e.ovf = full > 65535;
      end
      4'd2: begin
        e.r   = 16'((av + 65536 - bv) % 65536);
        e.ovf = av < bv;
      end
      4'd3: e.r = b;
      4'd4: e.r = (a == b) ? 16'd1 : 16'd0;
      4'd5: e.r = a & b;
      4'd6: e.r = a | b;
      4'd7: e.r = a ^ b;
      4'd8: begin
        full  = av * pw;
        e.r   = 16'(full % 65536);
        e.ovf = full > 65535;
      end
      4'd9:  e.r = 16'(av / pw);
      4'd10: e.r = (av < bv) ? 16'd1 : 16'd0;
`ifdef ALU_PIPE_MUL_EN
      4'd11: begin
        full  = av * bv;
        e.r   = 16'(full % 65536);
        e.ovf = full > 65535;
      end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = valid;
    bus.cop      = op;
    bus.reg_A    = a;
    bus.reg_B    = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [W-1:0] r,
                          input logic o, input logic i);
    checkOutput({tag, "_valid"},  32'(bus.out_valid), 32'(v));
    checkOutput({tag, "_result"}, 32'(bus.result),    32'(r));
    checkOutput({tag, "_ovf"},    32'(bus.OVF),       32'(o));
    checkOutput({tag, "_ill"},    32'(bus.ILL),       32'(i));
  endtask

  initial begin
    exp_t         q[$];
    exp_t         e;
    exp_t         held;
    logic         hold_valid;
    logic         pending;
    logic [3:0]   cur_op;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    int           lat;
    int           low_cnt;
    int           stale;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, '0, '0);

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkAll("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // Add with carry out.
    @(negedge clk);
    applyStimulus(1'b1, 4'b0001, 16'hFFFF, 16'h0001);
    #1 checkOutput("add_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, '0);
    checkAll("add", 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back subtract with borrow then equality.
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 16'd5, 16'd7);
    #1 checkOutput("b2b_ready0", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkAll("sub", 1'b1, 16'hFFFE, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0100, 16'd9, 16'd9);
    #1 checkOutput("b2b_ready1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, '0);
    checkAll("eq", 1'b1, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drained_valid", 32'(bus.out_valid), 32'd0);

    // Shift left with output back-pressure.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'b1000, 16'h8001, 16'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      checkAll("shl_hold", 1'b1, 16'h0002, 1'b1, 1'b0);
      checkOutput("shl_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 checkOutput("shl_in_ready_freed", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("shl_drained", 32'(bus.out_valid), 32'd0);

    // Illegal opcode.
    applyStimulus(1'b1, 4'b1111, 16'd3, 16'd4);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, '0);
    checkAll("ill", 1'b1, 16'h0000, 1'b0, 1'b1);

    // Multiply opcode: 300 * 300.
    @(negedge clk);
    applyStimulus(1'b1, 4'b1011, 16'd300, 16'd300);
    lat     = 0;
    low_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 4'd0, '0, '0);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (!bus.in_ready) low_cnt++;
    end
`ifdef ALU_PIPE_MUL_EN
    checkOutput("mul_latency", 32'(lat), 32'd17);
    checkOutput("mul_stall_cycles", 32'(low_cnt), 32'd16);
    checkAll("mul", 1'b1, 16'h5F90, 1'b1, 1'b0);
`else
    checkOutput("mul_latency", 32'(lat), 32'd1);
    checkAll("mul", 1'b1, 16'h0000, 1'b0, 1'b1);
`endif

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'b1011, 16'd300, 16'd300);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, '0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    checkAll("rst_mid", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checkOutput("no_stale_product", 32'(stale), 32'd0);

    // Randomized traffic scored against the model.
    hold_valid = 1'b0;
    pending    = 1'b0;
    cur_op     = '0;
    cur_a      = '0;
    cur_b      = '0;
    held       = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (hold_valid) begin
        checkOutput("hold_valid",  32'(bus.out_valid), 32'd1);
        checkOutput("hold_result", 32'(bus.result),    32'(held.r));
        checkOutput("hold_ovf",    32'(bus.OVF),       32'(held.ovf));
        checkOutput("hold_ill",    32'(bus.ILL),       32'(held.ill));
      end
      if (!pending && ($urandom_range(0, 3) != 0)) begin
        pending = 1'b1;
        cur_op  = 4'($urandom_range(0, 15));
        cur_a   = 16'($urandom);
        cur_b   = ($urandom_range(0, 3) == 0) ? cur_a : 16'($urandom);
      end
      applyStimulus(pending, cur_op, cur_a, cur_b);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("rand_out_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          checkOutput("rand_result", 32'(bus.result), 32'(e.r));
          checkOutput("rand_ovf",    32'(bus.OVF),    32'(e.ovf));
          checkOutput("rand_ill",    32'(bus.ILL),    32'(e.ill));
        end
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      held.r     = bus.result;
      held.ovf   = bus.OVF;
      held.ill   = bus.ILL;
      if (pending && bus.in_ready) begin
        q.push_back(model(cur_op, cur_a, cur_b));
        pending = 1'b0;
      end
    end

    // Drain whatever is still in flight, within a fixed budget.
    applyStimulus(1'b0, 4'd0, '0, '0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) begin
        e = q.pop_front();
        checkOutput("drain_result", 32'(bus.result), 32'(e.r));
        checkOutput("drain_ovf",    32'(bus.OVF),    32'(e.ovf));
        checkOutput("drain_ill",    32'(bus.ILL),    32'(e.ill));
      end
    end
    checkOutput("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
